bp_fe_stream_checker: RTL and testbench

//  Downstream consumer of the FE queue. Sits where the mock BE sits in FE trace demos.
//  - Dequeues fetch packets and checks their PCs against a sequential expected-PC model.
//  - Periodically injects synthetic PC redirects to exercise the FE redirect path.
//  - On a mismatch or injected redirect: issues an fe_cmd pc_redirect, clears the queue,

---
 rtl/bp_fe_pkg.sv | 12 +
 rtl/bp_fe_sat_counter.sv | 28 ++
 rtl/bp_fe_stream_checker.sv | 159 +++++++++++++++
 tb/tb_bp_fe_stream_checker.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/bp_fe_pkg.sv
// Shared types and constants for the FE stream checker.
package bp_fe_pkg;

    typedef enum logic [1:0] {
        e_chk_run   = 2'd0,
        e_chk_send  = 2'd1,
        e_chk_flush = 2'd2
    } bp_fe_chk_state_e;

    localparam int unsigned pc_step = 32'd4;

endpackage

// File: rtl/bp_fe_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module bp_fe_sat_counter
    import bp_fe_pkg::*;
#(
    parameter int width_p = 32
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               up_i,
    output logic [width_p-1:0] count_o
);

    logic [width_p-1:0] count_r;

    // Count register: increments on up_i until it reaches all-ones.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            count_r <= {width_p{1'b0}};
        end else if (up_i && (count_r != {width_p{1'b1}})) begin
            count_r <= count_r + width_p'(1'b1);
        end else begin
            count_r <= count_r;
        end
    end

    assign count_o = count_r;

endmodule

// File: rtl/bp_fe_stream_checker.sv
// FE queue consumer: checks PCs against a sequential model, injects periodic
// redirects, and resynchronises the FE after every redirect.
module bp_fe_stream_checker
    import bp_fe_pkg::*;
#(
    parameter int                       vaddr_width_p     = 39,
    parameter int                       instr_width_p     = 32,
    parameter logic [vaddr_width_p-1:0] first_pc_p        = vaddr_width_p'(32'h8000_0000),
    parameter int                       redirect_period_p = 16,
    parameter logic [vaddr_width_p-1:0] jump_offset_p     = vaddr_width_p'(32'h40),
    parameter int                       cnt_width_p       = 32
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic [vaddr_width_p-1:0] fe_queue_pc_i,
    input  logic [instr_width_p-1:0] fe_queue_instr_i,
    input  logic                     fe_queue_v_i,
    output logic                     fe_queue_yumi_o,
    output logic                     fe_queue_clr_o,
    output logic [vaddr_width_p-1:0] fe_cmd_pc_o,
    output logic                     fe_cmd_v_o,
    input  logic                     fe_cmd_ready_i,
    output logic [cnt_width_p-1:0]   instr_cnt_o,
    output logic [cnt_width_p-1:0]   redirect_cnt_o,
    output logic [cnt_width_p-1:0]   mismatch_cnt_o,
    output logic [cnt_width_p-1:0]   drop_cnt_o,
    output logic [instr_width_p-1:0] last_instr_o
);

    localparam bit          inject_en_c = (redirect_period_p != 0);
    localparam logic [31:0] period_c    = 32'(redirect_period_p);

    bp_fe_chk_state_e           state_r, state_n;
    logic                       cmd_v_r, cmd_v_n;
    logic [vaddr_width_p-1:0]   target_r, target_n;
    logic [vaddr_width_p-1:0]   exp_pc_r, exp_pc_n;
    logic [31:0]                period_cnt_r, period_cnt_n;
    logic [instr_width_p-1:0]   last_instr_r, last_instr_n;

    logic                       pc_hit_s;
    logic [vaddr_width_p-1:0]   exp_pc_inc_s;
    logic                       yumi_s, clr_s;
    logic                       match_s, mismatch_s, drop_s, handshake_s;

    // Next-state, datapath updates and handshake outputs.
    always_comb begin
        state_n      = state_r;
        cmd_v_n      = cmd_v_r;
        target_n     = target_r;
        exp_pc_n     = exp_pc_r;
        period_cnt_n = period_cnt_r;
        last_instr_n = last_instr_r;
        yumi_s       = 1'b0;
        clr_s        = 1'b0;
        match_s      = 1'b0;
        mismatch_s   = 1'b0;
        drop_s       = 1'b0;
        handshake_s  = 1'b0;
        pc_hit_s     = (fe_queue_pc_i == exp_pc_r);
        exp_pc_inc_s = exp_pc_r + vaddr_width_p'(pc_step);

        case (state_r)
            e_chk_run: begin
                yumi_s = fe_queue_v_i;
                if (fe_queue_v_i && pc_hit_s) begin
                    match_s      = 1'b1;
                    exp_pc_n     = exp_pc_inc_s;
                    last_instr_n = fe_queue_instr_i;
                    period_cnt_n = period_cnt_r + 32'd1;
                    if (inject_en_c && (period_cnt_n >= period_c)) begin
                        target_n = exp_pc_inc_s + jump_offset_p;
                        cmd_v_n  = 1'b1;
                        state_n  = e_chk_send;
                    end else begin
                        state_n  = e_chk_run;
                    end
                end else if (fe_queue_v_i) begin
                    // A wrong PC always wins over a pending injection.
                    mismatch_s = 1'b1;
                    target_n   = exp_pc_r;
                    cmd_v_n    = 1'b1;
                    state_n    = e_chk_send;
                end else begin
                    state_n = e_chk_run;
                end
            end
            e_chk_send: begin
                if (cmd_v_r && fe_cmd_ready_i) begin
                    handshake_s  = 1'b1;
                    clr_s        = 1'b1;
                    exp_pc_n     = target_r;
                    period_cnt_n = 32'd0;
                    cmd_v_n      = 1'b0;
                    state_n      = e_chk_flush;
                end else begin
                    state_n = e_chk_send;
                end
            end
            e_chk_flush: begin
                yumi_s = fe_queue_v_i;
                if (fe_queue_v_i && pc_hit_s) begin
                    match_s      = 1'b1;
                    exp_pc_n     = exp_pc_inc_s;
                    last_instr_n = fe_queue_instr_i;
                    period_cnt_n = 32'd1;
                    state_n      = e_chk_run;
                end else if (fe_queue_v_i) begin
                    drop_s  = 1'b1;
                    state_n = e_chk_flush;
                end else begin
                    state_n = e_chk_flush;
                end
            end
            default: begin
                cmd_v_n = 1'b0;
                state_n = e_chk_run;
            end
        endcase
    end

    // State and datapath registers; reset also kills an in-flight command.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r      <= e_chk_run;
            cmd_v_r      <= 1'b0;
            target_r     <= {vaddr_width_p{1'b0}};
            exp_pc_r     <= first_pc_p;
            period_cnt_r <= 32'd0;
            last_instr_r <= {instr_width_p{1'b0}};
        end else begin
            state_r      <= state_n;
            cmd_v_r      <= cmd_v_n;
            target_r     <= target_n;
            exp_pc_r     <= exp_pc_n;
            period_cnt_r <= period_cnt_n;
            last_instr_r <= last_instr_n;
        end
    end

    bp_fe_sat_counter #(.width_p(cnt_width_p)) instr_cnt_u (
        .clk_i(clk_i), .reset_n_i(reset_n_i), .up_i(match_s), .count_o(instr_cnt_o)
    );
    bp_fe_sat_counter #(.width_p(cnt_width_p)) redirect_cnt_u (
        .clk_i(clk_i), .reset_n_i(reset_n_i), .up_i(handshake_s), .count_o(redirect_cnt_o)
    );
    bp_fe_sat_counter #(.width_p(cnt_width_p)) mismatch_cnt_u (
        .clk_i(clk_i), .reset_n_i(reset_n_i), .up_i(mismatch_s), .count_o(mismatch_cnt_o)
    );
    bp_fe_sat_counter #(.width_p(cnt_width_p)) drop_cnt_u (
        .clk_i(clk_i), .reset_n_i(reset_n_i), .up_i(drop_s), .count_o(drop_cnt_o)
    );

    assign fe_queue_yumi_o = yumi_s;
    assign fe_queue_clr_o  = clr_s;
    assign fe_cmd_v_o      = cmd_v_r;
    assign fe_cmd_pc_o     = target_r;
    assign last_instr_o    = last_instr_r;

endmodule

// File: tb/tb_bp_fe_stream_checker.sv
// Scoreboard bench for bp_fe_stream_checker across three parameterisations.
module tb_bp_fe_stream_checker;

    localparam logic [38:0] base_c = 39'h80_0000_00;

    logic        clk;
    logic        rst_n;
    logic [38:0] pc;
    logic [31:0] instr;
    logic        v;
    logic        ready;
    logic [1:0]  sel;

    logic        yumi_w   [3];
    logic        clr_w    [3];
    logic        cmd_v_w  [3];
    logic [38:0] cmd_pc_w [3];
    logic [31:0] last_w   [3];
    logic [31:0] icnt_w [2], rcnt_w [2], mcnt_w [2], dcnt_w [2];
    logic [3:0]  icnt2, rcnt2, mcnt2, dcnt2;

    logic        sel_yumi, sel_clr, sel_cmd_v;
    logic [38:0] sel_cmd_pc;

    int checks = 0;
    int errors = 0;
    logic [38:0] exp_q [$];
    logic [38:0] cmd_q [$];

    bp_fe_stream_checker #(.redirect_period_p(0)) dut0 (
        .clk_i(clk), .reset_n_i(rst_n), .fe_queue_pc_i(pc), .fe_queue_instr_i(instr),
        .fe_queue_v_i(v), .fe_queue_yumi_o(yumi_w[0]), .fe_queue_clr_o(clr_w[0]),
        .fe_cmd_pc_o(cmd_pc_w[0]), .fe_cmd_v_o(cmd_v_w[0]), .fe_cmd_ready_i(ready),
        .instr_cnt_o(icnt_w[0]), .redirect_cnt_o(rcnt_w[0]), .mismatch_cnt_o(mcnt_w[0]),
        .drop_cnt_o(dcnt_w[0]), .last_instr_o(last_w[0])
    );

    bp_fe_stream_checker #(.redirect_period_p(16)) dut1 (
        .clk_i(clk), .reset_n_i(rst_n), .fe_queue_pc_i(pc), .fe_queue_instr_i(instr),
        .fe_queue_v_i(v), .fe_queue_yumi_o(yumi_w[1]), .fe_queue_clr_o(clr_w[1]),
        .fe_cmd_pc_o(cmd_pc_w[1]), .fe_cmd_v_o(cmd_v_w[1]), .fe_cmd_ready_i(ready),
        .instr_cnt_o(icnt_w[1]), .redirect_cnt_o(rcnt_w[1]), .mismatch_cnt_o(mcnt_w[1]),
        .drop_cnt_o(dcnt_w[1]), .last_instr_o(last_w[1])
    );

    bp_fe_stream_checker #(.redirect_period_p(0), .cnt_width_p(4)) dut2 (
        .clk_i(clk), .reset_n_i(rst_n), .fe_queue_pc_i(pc), .fe_queue_instr_i(instr),
        .fe_queue_v_i(v), .fe_queue_yumi_o(yumi_w[2]), .fe_queue_clr_o(clr_w[2]),
        .fe_cmd_pc_o(cmd_pc_w[2]), .fe_cmd_v_o(cmd_v_w[2]), .fe_cmd_ready_i(ready),
        .instr_cnt_o(icnt2), .redirect_cnt_o(rcnt2), .mismatch_cnt_o(mcnt2),
        .drop_cnt_o(dcnt2), .last_instr_o(last_w[2])
    );

    always #5 clk = ~clk;

    always_comb begin
        case (sel)
            2'd1:    begin sel_yumi = yumi_w[1]; sel_clr = clr_w[1]; sel_cmd_v = cmd_v_w[1]; sel_cmd_pc = cmd_pc_w[1]; end
            2'd2:    begin sel_yumi = yumi_w[2]; sel_clr = clr_w[2]; sel_cmd_v = cmd_v_w[2]; sel_cmd_pc = cmd_pc_w[2]; end
            default: begin sel_yumi = yumi_w[0]; sel_clr = clr_w[0]; sel_cmd_v = cmd_v_w[0]; sel_cmd_pc = cmd_pc_w[0]; end
        endcase
    end

    function automatic logic [31:0] instr_of(input logic [38:0] p);
        return p[31:0] ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops expected dequeues and redirect commands as the DUT presents them.
    always @(negedge clk) begin
        if (rst_n) begin
            if (sel_yumi) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_yumi", {63'd0, sel_yumi}, 64'd0);
                end else begin
                    chk("yumi_pc", {25'd0, pc}, {25'd0, exp_q.pop_front()});
                end
                chk("yumi_clr_excl", {63'd0, sel_clr}, 64'd0);
            end
            if (sel_cmd_v && ready) begin
                if (cmd_q.size() == 0) begin
                    chk("unexpected_cmd", 64'd1, 64'd0);
                end else begin
                    chk("cmd_pc", {25'd0, sel_cmd_pc}, {25'd0, cmd_q.pop_front()});
                end
                chk("clr_on_handshake", {63'd0, sel_clr}, 64'd1);
            end else if (sel_clr) begin
                chk("clr_without_handshake", 64'd1, 64'd0);
            end
        end
    end

    task automatic feed(input logic [38:0] p, input bit take);
        if (take) exp_q.push_back(p);
        pc    = p;
        instr = instr_of(p);
        v     = 1'b1;
        @(posedge clk); #1;
        v     = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic do_reset();
        v = 1'b0; ready = 1'b0;
        rst_n = 1'b0;
        idle(2);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        chk("cmd_q_drained", 64'(cmd_q.size()), 64'd0);
        exp_q.delete();
        cmd_q.delete();
        rst_n = 1'b1;
        idle(1);
    endtask

    // Waits for the command, holds ready low for `hold` cycles, then accepts it.
    task automatic do_cmd(input logic [38:0] tgt, input int hold);
        int n;
        n = 0;
        cmd_q.push_back(tgt);
        while (!sel_cmd_v && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("cmd_v_rise", {63'd0, sel_cmd_v}, 64'd1);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("cmd_v_hold", {63'd0, sel_cmd_v}, 64'd1);
            chk("cmd_pc_hold", {25'd0, sel_cmd_pc}, {25'd0, tgt});
            chk("yumi_in_send", {63'd0, sel_yumi}, 64'd0);
        end
        ready = 1'b1;
        @(posedge clk); #1;
        ready = 1'b0;
        v     = 1'b0;
        chk("cmd_v_after_hs", {63'd0, sel_cmd_v}, 64'd0);
    endtask

    initial begin
        clk = 1'b0; rst_n = 1'b0; pc = 39'd0; instr = 32'd0; v = 1'b0; ready = 1'b0; sel = 2'd0;

        // 1: in-order stream, no injection
        do_reset();
        chk("rst_instr_cnt", 64'(icnt_w[0]), 64'd0);
        chk("rst_cmd_v", {63'd0, cmd_v_w[0]}, 64'd0);
        chk("rst_cmd_pc", {25'd0, cmd_pc_w[0]}, 64'd0);
        chk("rst_last_instr", 64'(last_w[0]), 64'd0);
        for (int i = 0; i < 4; i++) feed(base_c + 39'(4 * i), 1'b1);
        chk("t1_instr_cnt", 64'(icnt_w[0]), 64'd4);
        chk("t1_mismatch_cnt", 64'(mcnt_w[0]), 64'd0);
        chk("t1_cmd_v", {63'd0, cmd_v_w[0]}, 64'd0);
        chk("t1_last_instr", 64'(last_w[0]), 64'(instr_of(base_c + 39'h0C)));

        // 2: mismatch triggers a redirect to the expected PC
        do_reset();
        feed(base_c, 1'b1);
        feed(base_c + 39'h10, 1'b1);
        chk("t2_mismatch_cnt", 64'(mcnt_w[0]), 64'd1);
        chk("t2_cmd_v", {63'd0, cmd_v_w[0]}, 64'd1);
        chk("t2_cmd_pc", {25'd0, cmd_pc_w[0]}, {25'd0, base_c + 39'h4});
        do_cmd(base_c + 39'h4, 2);
        chk("t2_redirect_cnt", 64'(rcnt_w[0]), 64'd1);

        // 3: flush discards stale packets until the target arrives
        idle(3);
        chk("t3_empty_no_drop", 64'(dcnt_w[0]), 64'd0);
        feed(base_c + 39'h14, 1'b1);
        feed(base_c + 39'h18, 1'b1);
        feed(base_c + 39'h04, 1'b1);
        chk("t3_drop_cnt", 64'(dcnt_w[0]), 64'd2);
        chk("t3_instr_cnt", 64'(icnt_w[0]), 64'd2);
        feed(base_c + 39'h08, 1'b1);
        chk("t3_resync_cnt", 64'(icnt_w[0]), 64'd3);
        chk("t3_resync_mismatch", 64'(mcnt_w[0]), 64'd1);
        chk("t3_resync_cmd_v", {63'd0, cmd_v_w[0]}, 64'd0);

        // 4: injected redirect after 16 matches, ready held low
        sel = 2'd1;
        do_reset();
        for (int i = 0; i < 16; i++) feed(base_c + 39'(4 * i), 1'b1);
        chk("t4_instr_cnt", 64'(icnt_w[1]), 64'd16);
        chk("t4_mismatch_cnt", 64'(mcnt_w[1]), 64'd0);
        pc = base_c + 39'h40; instr = instr_of(pc); v = 1'b1;
        do_cmd(base_c + 39'h80, 5);
        chk("t4_redirect_cnt", 64'(rcnt_w[1]), 64'd1);
        feed(base_c + 39'h80, 1'b1);
        chk("t4_flush_match", 64'(icnt_w[1]), 64'd17);
        chk("t4_no_drop", 64'(dcnt_w[1]), 64'd0);

        // 5: async reset while a command is pending
        do_reset();
        for (int i = 0; i < 16; i++) feed(base_c + 39'(4 * i), 1'b1);
        chk("t5_in_send", {63'd0, cmd_v_w[1]}, 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_async_cmd_v", {63'd0, cmd_v_w[1]}, 64'd0);
        chk("t5_async_icnt", 64'(icnt_w[1]), 64'd0);
        chk("t5_async_cmd_pc", {25'd0, cmd_pc_w[1]}, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(1);
        feed(base_c, 1'b1);
        chk("t5_after_rst", 64'(icnt_w[1]), 64'd1);

        // 6: 4-bit counter saturation
        sel = 2'd2;
        do_reset();
        for (int i = 0; i < 14; i++) feed(base_c + 39'(4 * i), 1'b1);
        chk("t6_pre_sat", 64'(icnt2), 64'hE);
        for (int i = 14; i < 20; i++) feed(base_c + 39'(4 * i), 1'b1);
        chk("t6_saturated", 64'(icnt2), 64'hF);
        chk("t6_mismatch", 64'(mcnt2), 64'd0);

        idle(2);
        chk("final_queue_drained", 64'(exp_q.size()), 64'd0);
        chk("final_cmd_q_drained", 64'(cmd_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
